// File: rtl/x86_insn_length_sequencer.sv
// Byte-serial x86-64 instruction length sequencer: walks prefixes, REX, opcode,
// ModRM, SIB, displacement and immediate, then presents one boundary record.
module x86_insn_length_sequencer #(
    parameter int MAX_LEN = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [255:0] modrm_map,
    input  logic         in_valid,
    input  logic [7:0]   in_byte,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_len,
    output logic [7:0]   out_opcode,
    output logic         out_esc,
    output logic [3:0]   out_rex,
    output logic [4:0]   out_pfx,
    output logic [2:0]   out_seg,
    output logic         out_has_modrm,
    output logic [7:0]   out_modrm,
    output logic         out_has_sib,
    output logic [2:0]   out_disp_len,
    output logic [3:0]   out_imm_len,
    output logic         out_err
);
    localparam logic [2:0] PREFIX = 3'd0;
    localparam logic [2:0] OPC2   = 3'd1;
    localparam logic [2:0] MODRM  = 3'd2;
    localparam logic [2:0] SIB    = 3'd3;
    localparam logic [2:0] DISP   = 3'd4;
    localparam logic [2:0] IMM    = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam logic [3:0] LAST_IDX = 4'(MAX_LEN - 1);

    logic [2:0] state, next_state;
    logic [3:0] cnt, next_cnt;
    logic [3:0] next_len;
    logic [7:0] next_opcode;
    logic       next_esc;
    logic [3:0] next_rex;
    logic [4:0] next_pfx;
    logic [2:0] next_seg;
    logic       next_has_modrm;
    logic [7:0] next_modrm;
    logic       next_has_sib;
    logic [2:0] next_disp;
    logic [3:0] next_imm;
    logic       next_err;

    logic       accept;
    logic       op16;
    logic       map_hit;
    logic [3:0] imm_one;
    logic       modrm_two;
    logic [3:0] imm_two;
    logic [2:0] disp_m;
    logic [3:0] imm_m;
    logic [2:0] disp_s;

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign op16      = out_pfx[0];
    assign map_hit   = modrm_map[8'd255 - in_byte];

    // Immediate size of a one-byte opcode, given the prefixes latched so far.
    always_comb begin
        imm_one = 4'd0;
        if (in_byte[7:6] == 2'b00 && in_byte[2:0] == 3'd4)
            imm_one = 4'd1;
        else if (in_byte[7:6] == 2'b00 && in_byte[2:0] == 3'd5)
            imm_one = op16 ? 4'd2 : 4'd4;
        else if (in_byte inside {8'h6A, 8'h6B, [8'h70:8'h7F], 8'h80, 8'h82, 8'h83, 8'hA8,
                                 [8'hB0:8'hB7], 8'hC0, 8'hC1, 8'hC6, 8'hCD, 8'hD4, 8'hD5,
                                 [8'hE0:8'hE7], 8'hEB})
            imm_one = 4'd1;
        else if (in_byte inside {8'h68, 8'h69, 8'h81, 8'hA9, 8'hC7})
            imm_one = op16 ? 4'd2 : 4'd4;
        else if (in_byte inside {8'hE8, 8'hE9})
            imm_one = 4'd4;
        else if (in_byte inside {[8'hB8:8'hBF]})
            imm_one = out_rex[3] ? 4'd8 : (op16 ? 4'd2 : 4'd4);
        else if (in_byte inside {8'hC2, 8'hCA})
            imm_one = 4'd2;
        else if (in_byte == 8'hC8)
            imm_one = 4'd3;
        else if (in_byte inside {[8'hA0:8'hA3]})
            imm_one = out_pfx[1] ? 4'd4 : 4'd8;
    end

    always_comb begin
        modrm_two = !(in_byte inside {8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0B, 8'h31, 8'h77,
                                      8'hA2, [8'h80:8'h8F], [8'hC8:8'hCF]});
        imm_two = 4'd0;
        if (in_byte inside {[8'h80:8'h8F]})
            imm_two = 4'd4;
        else if (in_byte inside {[8'h70:8'h73], 8'hA4, 8'hAC, 8'hBA, 8'hC2, 8'hC4, 8'hC5, 8'hC6})
            imm_two = 4'd1;
    end

    // F6/F7 only carry an immediate for the TEST form (ModRM.reg == 0).
    always_comb begin
        disp_m = 3'd0;
        if (in_byte[7:6] == 2'b01)
            disp_m = 3'd1;
        else if (in_byte[7:6] == 2'b10 || (in_byte[7:6] == 2'b00 && in_byte[2:0] == 3'd5))
            disp_m = 3'd4;
        imm_m = out_imm_len;
        if (!out_esc && out_opcode == 8'hF6 && in_byte[5:3] == 3'd0)
            imm_m = 4'd1;
        else if (!out_esc && out_opcode == 8'hF7 && in_byte[5:3] == 3'd0)
            imm_m = op16 ? 4'd2 : 4'd4;
        disp_s = (out_modrm[7:6] == 2'b00 && in_byte[2:0] == 3'd5) ? 3'd4 : out_disp_len;
    end

    always_comb begin
        next_state     = state;
        next_cnt       = cnt;
        next_len       = out_len;
        next_opcode    = out_opcode;
        next_esc       = out_esc;
        next_rex       = out_rex;
        next_pfx       = out_pfx;
        next_seg       = out_seg;
        next_has_modrm = out_has_modrm;
        next_modrm     = out_modrm;
        next_has_sib   = out_has_sib;
        next_disp      = out_disp_len;
        next_imm       = out_imm_len;
        next_err       = out_err;
        if (state == DONE) begin
            if (out_ready) begin
                next_state     = PREFIX;
                next_cnt       = 4'd0;
                next_len       = 4'd0;
                next_opcode    = 8'd0;
                next_esc       = 1'b0;
                next_rex       = 4'd0;
                next_pfx       = 5'd0;
                next_seg       = 3'd0;
                next_has_modrm = 1'b0;
                next_modrm     = 8'd0;
                next_has_sib   = 1'b0;
                next_disp      = 3'd0;
                next_imm       = 4'd0;
                next_err       = 1'b0;
            end
        end else if (accept) begin
            next_len = out_len + 4'd1;
            case (state)
                PREFIX: begin
                    case (in_byte)
                        8'h26: begin next_seg = 3'd1; next_rex = 4'd0; end
                        8'h2E: begin next_seg = 3'd2; next_rex = 4'd0; end
                        8'h36: begin next_seg = 3'd3; next_rex = 4'd0; end
                        8'h3E: begin next_seg = 3'd4; next_rex = 4'd0; end
                        8'h64: begin next_seg = 3'd5; next_rex = 4'd0; end
                        8'h65: begin next_seg = 3'd6; next_rex = 4'd0; end
                        8'h66: begin next_pfx[0] = 1'b1; next_rex = 4'd0; end
                        8'h67: begin next_pfx[1] = 1'b1; next_rex = 4'd0; end
                        8'hF0: begin next_pfx[2] = 1'b1; next_rex = 4'd0; end
                        8'hF2: begin next_pfx[3] = 1'b1; next_rex = 4'd0; end
                        8'hF3: begin next_pfx[4] = 1'b1; next_rex = 4'd0; end
                        8'h0F: begin next_esc = 1'b1; next_state = OPC2; end
                        default: begin
                            if (in_byte[7:4] == 4'h4) begin
                                next_rex = in_byte[3:0];
                            end else begin
                                next_opcode    = in_byte;
                                next_has_modrm = map_hit;
                                next_imm       = imm_one;
                                if (map_hit)
                                    next_state = MODRM;
                                else if (imm_one != 4'd0) begin
                                    next_state = IMM;
                                    next_cnt   = imm_one;
                                end else
                                    next_state = DONE;
                            end
                        end
                    endcase
                end
                OPC2: begin
                    next_opcode    = in_byte;
                    next_has_modrm = modrm_two;
                    next_imm       = imm_two;
                    if (modrm_two)
                        next_state = MODRM;
                    else if (imm_two != 4'd0) begin
                        next_state = IMM;
                        next_cnt   = imm_two;
                    end else
                        next_state = DONE;
                end
                MODRM: begin
                    next_modrm = in_byte;
                    next_disp  = disp_m;
                    next_imm   = imm_m;
                    if (in_byte[7:6] != 2'b11 && in_byte[2:0] == 3'd4) begin
                        next_has_sib = 1'b1;
                        next_state   = SIB;
                    end else if (disp_m != 3'd0) begin
                        next_state = DISP;
                        next_cnt   = {1'b0, disp_m};
                    end else if (imm_m != 4'd0) begin
                        next_state = IMM;
                        next_cnt   = imm_m;
                    end else
                        next_state = DONE;
                end
                SIB: begin
                    next_disp = disp_s;
                    if (disp_s != 3'd0) begin
                        next_state = DISP;
                        next_cnt   = {1'b0, disp_s};
                    end else if (out_imm_len != 4'd0) begin
                        next_state = IMM;
                        next_cnt   = out_imm_len;
                    end else
                        next_state = DONE;
                end
                DISP: begin
                    next_cnt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (out_imm_len != 4'd0) begin
                            next_state = IMM;
                            next_cnt   = out_imm_len;
                        end else
                            next_state = DONE;
                    end
                end
                IMM: begin
                    next_cnt = cnt - 4'd1;
                    if (cnt == 4'd1)
                        next_state = DONE;
                end
                default: next_state = PREFIX;
            endcase
            // Hitting the architectural limit mid-instruction ends the record as an error.
            if (out_len == LAST_IDX && next_state != DONE) begin
                next_state = DONE;
                next_err   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state         <= PREFIX;
            cnt           <= 4'd0;
            out_len       <= 4'd0;
            out_opcode    <= 8'd0;
            out_esc       <= 1'b0;
            out_rex       <= 4'd0;
            out_pfx       <= 5'd0;
            out_seg       <= 3'd0;
            out_has_modrm <= 1'b0;
            out_modrm     <= 8'd0;
            out_has_sib   <= 1'b0;
            out_disp_len  <= 3'd0;
            out_imm_len   <= 4'd0;
            out_err       <= 1'b0;
        end else begin
            state         <= next_state;
            cnt           <= next_cnt;
            out_len       <= next_len;
            out_opcode    <= next_opcode;
            out_esc       <= next_esc;
            out_rex       <= next_rex;
            out_pfx       <= next_pfx;
            out_seg       <= next_seg;
            out_has_modrm <= next_has_modrm;
            out_modrm     <= next_modrm;
            out_has_sib   <= next_has_sib;
            out_disp_len  <= next_disp;
            out_imm_len   <= next_imm;
            out_err       <= next_err;
        end
    end
endmodule

// File: tb/tb_x86_insn_length_sequencer.sv
// Directed bench for x86_insn_length_sequencer: byte sequences with hand-computed
// boundary records, including length-limit, back-pressure and flush cases.
module tb_x86_insn_length_sequencer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic [255:0] modrm_map;
    logic         in_valid = 1'b0;
    logic [7:0]   in_byte = 8'd0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [3:0]   out_len;
    logic [7:0]   out_opcode;
    logic         out_esc;
    logic [3:0]   out_rex;
    logic [4:0]   out_pfx;
    logic [2:0]   out_seg;
    logic         out_has_modrm;
    logic [7:0]   out_modrm;
    logic         out_has_sib;
    logic [2:0]   out_disp_len;
    logic [3:0]   out_imm_len;
    logic         out_err;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] txq[$];

    x86_insn_length_sequencer dut (
        .clk(clk), .reset(reset), .flush(flush), .modrm_map(modrm_map),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_len(out_len),
        .out_opcode(out_opcode), .out_esc(out_esc), .out_rex(out_rex),
        .out_pfx(out_pfx), .out_seg(out_seg), .out_has_modrm(out_has_modrm),
        .out_modrm(out_modrm), .out_has_sib(out_has_sib),
        .out_disp_len(out_disp_len), .out_imm_len(out_imm_len), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Called at a negedge; holds the byte until the sequencer takes it.
    task automatic sendByte(input logic [7:0] b);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 64'd0, 64'd1);
        in_valid = 1'b1;
        in_byte  = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_byte  = 8'hXX;
    endtask

    task automatic applyStimulus(input bit gap);
        foreach (txq[i]) begin
            sendByte(txq[i]);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic waitRecord();
        int guard = 0;
        while (!out_valid && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) checkOutput("record_timeout", 64'd0, 64'd1);
    endtask

    task automatic checkRecord(input string name, input logic [3:0] len, input logic [7:0] op,
                               input logic esc, input logic [3:0] rex, input logic [4:0] pfx,
                               input logic [2:0] seg, input logic hm, input logic [7:0] modrm,
                               input logic sib, input logic [2:0] disp, input logic [3:0] imm,
                               input logic err);
        waitRecord();
        checkOutput({name, ".len"},    64'(out_len),       64'(len));
        checkOutput({name, ".opcode"}, 64'(out_opcode),    64'(op));
        checkOutput({name, ".esc"},    64'(out_esc),       64'(esc));
        checkOutput({name, ".rex"},    64'(out_rex),       64'(rex));
        checkOutput({name, ".pfx"},    64'(out_pfx),       64'(pfx));
        checkOutput({name, ".seg"},    64'(out_seg),       64'(seg));
        checkOutput({name, ".has_modrm"}, 64'(out_has_modrm), 64'(hm));
        checkOutput({name, ".modrm"},  64'(out_modrm),     64'(modrm));
        checkOutput({name, ".sib"},    64'(out_has_sib),   64'(sib));
        checkOutput({name, ".disp"},   64'(out_disp_len),  64'(disp));
        checkOutput({name, ".imm"},    64'(out_imm_len),   64'(imm));
        checkOutput({name, ".err"},    64'(out_err),       64'(err));
        checkOutput({name, ".in_ready_done"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({name, ".valid_cleared"}, 64'(out_valid), 64'd0);
        checkOutput({name, ".len_cleared"},   64'(out_len),   64'd0);
    endtask

    task automatic setModrm(input logic [7:0] op);
        modrm_map[8'd255 - op] = 1'b1;
    endtask

    initial begin
        modrm_map = '0;
        for (int op = 0; op < 64; op++)
            if (op[2] == 1'b0) setModrm(8'(op));
        for (int op = 8'h80; op <= 8'h8F; op++) setModrm(8'(op));
        for (int op = 8'hD0; op <= 8'hD3; op++) setModrm(8'(op));
        for (int op = 8'hD8; op <= 8'hDF; op++) setModrm(8'(op));
        setModrm(8'h62); setModrm(8'h63); setModrm(8'h69); setModrm(8'h6B);
        setModrm(8'hC0); setModrm(8'hC1); setModrm(8'hC4); setModrm(8'hC5);
        setModrm(8'hC6); setModrm(8'hC7); setModrm(8'hF6); setModrm(8'hF7);
        setModrm(8'hFE); setModrm(8'hFF);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset.valid", 64'(out_valid), 64'd0);
        checkOutput("reset.ready", 64'(in_ready),  64'd1);
        checkOutput("reset.len",   64'(out_len),   64'd0);

        txq = '{8'h48, 8'h89, 8'hE5};
        applyStimulus(1'b0);
        checkRecord("mov_rbp", 4'd3, 8'h89, 0, 4'h8, 5'b00000, 3'd0, 1, 8'hE5, 0, 3'd0, 4'd0, 0);

        txq = '{8'h66, 8'h05, 8'h34, 8'h12};
        applyStimulus(1'b0);
        checkRecord("add_ax", 4'd4, 8'h05, 0, 4'h0, 5'b00001, 3'd0, 0, 8'h00, 0, 3'd0, 4'd2, 0);

        txq = '{8'h48, 8'hB8, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        applyStimulus(1'b0);
        checkRecord("movabs", 4'd10, 8'hB8, 0, 4'h8, 5'b00000, 3'd0, 0, 8'h00, 0, 3'd0, 4'd8, 0);

        txq = '{8'h8B, 8'h44, 8'h24, 8'h08};
        applyStimulus(1'b1);
        checkRecord("sib_d8", 4'd4, 8'h8B, 0, 4'h0, 5'b00000, 3'd0, 1, 8'h44, 1, 3'd1, 4'd0, 0);

        txq = '{8'h0F, 8'h84, 8'h10, 8'h20, 8'h30, 8'h40};
        applyStimulus(1'b0);
        checkRecord("jz_rel32", 4'd6, 8'h84, 1, 4'h0, 5'b00000, 3'd0, 0, 8'h00, 0, 3'd0, 4'd4, 0);

        txq = '{8'hF6, 8'hC0, 8'h05};
        applyStimulus(1'b0);
        checkRecord("test_imm", 4'd3, 8'hF6, 0, 4'h0, 5'b00000, 3'd0, 1, 8'hC0, 0, 3'd0, 4'd1, 0);

        txq = '{8'hF6, 8'hD8};
        applyStimulus(1'b0);
        checkRecord("neg_noimm", 4'd2, 8'hF6, 0, 4'h0, 5'b00000, 3'd0, 1, 8'hD8, 0, 3'd0, 4'd0, 0);

        txq = '{8'h66, 8'hF7, 8'hC0, 8'h34, 8'h12};
        applyStimulus(1'b0);
        checkRecord("test_ax", 4'd5, 8'hF7, 0, 4'h0, 5'b00001, 3'd0, 1, 8'hC0, 0, 3'd0, 4'd2, 0);

        txq = '{8'h2E, 8'h64, 8'hC3};
        applyStimulus(1'b0);
        checkRecord("seg_last", 4'd3, 8'hC3, 0, 4'h0, 5'b00000, 3'd5, 0, 8'h00, 0, 3'd0, 4'd0, 0);

        txq = '{8'h48, 8'h66, 8'h90};
        applyStimulus(1'b0);
        checkRecord("rex_clear", 4'd3, 8'h90, 0, 4'h0, 5'b00001, 3'd0, 0, 8'h00, 0, 3'd0, 4'd0, 0);

        txq = '{8'h8B, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus(1'b0);
        checkRecord("rip_rel", 4'd6, 8'h8B, 0, 4'h0, 5'b00000, 3'd0, 1, 8'h05, 0, 3'd4, 4'd0, 0);

        txq = '{8'h8B, 8'h04, 8'h25, 8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus(1'b0);
        checkRecord("sib_abs", 4'd7, 8'h8B, 0, 4'h0, 5'b00000, 3'd0, 1, 8'h04, 1, 3'd4, 4'd0, 0);

        txq = '{8'h67, 8'hA0, 8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus(1'b0);
        checkRecord("moffs32", 4'd6, 8'hA0, 0, 4'h0, 5'b00010, 3'd0, 0, 8'h00, 0, 3'd0, 4'd4, 0);

        txq = '{8'hC8, 8'h10, 8'h00, 8'h01};
        applyStimulus(1'b0);
        checkRecord("enter", 4'd4, 8'hC8, 0, 4'h0, 5'b00000, 3'd0, 0, 8'h00, 0, 3'd0, 4'd3, 0);

        txq.delete();
        repeat (14) txq.push_back(8'h66);
        txq.push_back(8'h90);
        applyStimulus(1'b0);
        checkRecord("len15_ok", 4'd15, 8'h90, 0, 4'h0, 5'b00001, 3'd0, 0, 8'h00, 0, 3'd0, 4'd0, 0);

        txq.delete();
        repeat (15) txq.push_back(8'h66);
        applyStimulus(1'b0);
        checkRecord("too_long", 4'd15, 8'h00, 0, 4'h0, 5'b00001, 3'd0, 0, 8'h00, 0, 3'd0, 4'd0, 1);
        txq = '{8'h66, 8'h90};
        applyStimulus(1'b0);
        checkRecord("after_err", 4'd2, 8'h90, 0, 4'h0, 5'b00001, 3'd0, 0, 8'h00, 0, 3'd0, 4'd0, 0);

        txq = '{8'h90};
        applyStimulus(1'b0);
        waitRecord();
        for (int c = 0; c < 5; c++) begin
            checkOutput("hold.valid",  64'(out_valid),  64'd1);
            checkOutput("hold.len",    64'(out_len),    64'd1);
            checkOutput("hold.opcode", 64'(out_opcode), 64'h90);
            checkOutput("hold.ready",  64'(in_ready),   64'd0);
            @(negedge clk);
        end
        checkRecord("nop", 4'd1, 8'h90, 0, 4'h0, 5'b00000, 3'd0, 0, 8'h00, 0, 3'd0, 4'd0, 0);

        txq = '{8'h48, 8'h8B};
        applyStimulus(1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush.valid", 64'(out_valid), 64'd0);
        checkOutput("flush.ready", 64'(in_ready),  64'd1);
        checkOutput("flush.rex",   64'(out_rex),   64'd0);
        txq = '{8'hC3};
        applyStimulus(1'b0);
        checkRecord("ret", 4'd1, 8'hC3, 0, 4'h0, 5'b00000, 3'd0, 0, 8'h00, 0, 3'd0, 4'd0, 0);

        txq = '{8'h90};
        applyStimulus(1'b0);
        waitRecord();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_done.valid", 64'(out_valid), 64'd0);
        checkOutput("flush_done.len",   64'(out_len),   64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/x86_insn_length_sequencer.md
Name: x86_insn_length_sequencer

Overview:
Byte-serial front-end sequencer for the x86-64 decoder. It consumes instruction bytes from the fetch buffer one per handshake and walks them through legacy prefixes, REX, opcode (1-byte or 0F-escaped), ModRM, SIB, displacement and immediate. It emits one boundary record per instruction to the decode stage. One-byte ModRM presence comes from the opcode ModRM bitmap via an input port; everything else is fixed in this block.

Parameters:
MAX_LEN, 15, architectural instruction length limit in bytes.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous abort of the instruction in progress (branch redirect)
modrm_map  input  256  one-byte ModRM bitmap; opcode N needs ModRM iff modrm_map[255-N]
in_valid  input  1  in_byte is valid
in_byte  input  8  next instruction byte
in_ready  output  1  byte accepted when in_valid && in_ready
out_valid  output  1  instruction record valid
out_ready  input  1  decode stage accepts the record
out_len  output  4  total bytes, 1..15
out_opcode  output  8  opcode byte (second byte if escaped)
out_esc  output  1  opcode was 0F-escaped
out_rex  output  4  REX.WRXB, 0 if no REX
out_pfx  output  5  {F3,F2,F0,67,66} seen
out_seg  output  3  0 none, 1 ES, 2 CS, 3 SS, 4 DS, 5 FS, 6 GS (last one wins)
out_has_modrm  output  1  ModRM present
out_modrm  output  8  ModRM byte, 0 if absent
out_has_sib  output  1  SIB present
out_disp_len  output  3  0, 1 or 4
out_imm_len  output  4  0, 1, 2, 3, 4 or 8
out_err  output  1  length exceeded MAX_LEN

Behaviour:
- Reset and flush: state PREFIX, all record fields 0, out_valid=0, in_ready=1 on the next cycle. Reset overrides flush, and flush overrides everything else, including a pending out_valid.
- States: PREFIX, OPC2, MODRM, SIB, DISP, IMM, DONE. in_ready=1 in every state except DONE.
- PREFIX:
  - 26/2E/36/3E/64/65 set seg.
  - 66/67/F0/F2/F3 set pfx bits.
  - 40-4F latch REX; a later legacy prefix clears the latched REX.
  - 0F goes to OPC2.
  - Any other byte is the opcode. Evaluate the one-byte rules; the next state is MODRM, else IMM if imm>0, else DONE.
- OPC2: the byte is the opcode.
  - No ModRM for 05, 06, 07, 08, 09, 0B, 31, 77, A2, 80-8F, C8-CF; ModRM for all others.
  - imm4 for 80-8F; imm1 for 70-73, A4, AC, BA, C2, C4, C5, C6.
- One-byte immediate rules (op16 = 66 seen):
  - imm1: low byte 00-3F with op[2:0]=4; 6A, 6B, 70-7F, 80, 82, 83, A8, B0-B7, C0, C1, C6, CD, D4, D5, E0-E7, EB.
  - imm4, or imm2 if op16: 00-3F with op[2:0]=5; 68, 69, 81, A9, C7.
  - imm4: E8, E9.
  - B8-BF: imm8 if REX.W, else imm2 if op16, else imm4.
  - imm2: C2, CA. imm3: C8.
  - A0-A3: imm8, or imm4 if 67 seen.
  - F6 imm1 and F7 imm4 (imm2 if op16), only if ModRM.reg==0; resolved in MODRM.
- MODRM:
  - mod=11: no displacement.
  - mod=01: disp1.
  - mod=10: disp4.
  - mod=00 with rm=101: disp4.
  - mod!=11 with rm=100: next state SIB.
  - Otherwise next state DISP if disp>0, else IMM if imm>0, else DONE.
- SIB: if mod=00 and base=101, disp4. Then continue to DISP/IMM/DONE.
- DISP/IMM: a 4-bit down-counter is loaded with the length and decremented per accepted byte. At zero, exit to IMM (when imm>0) or DONE.
- out_valid rises the cycle after the final byte handshake. The record stays stable while out_valid && !out_ready. On handshake, the record clears and the state returns to PREFIX, so minimum latency is len+1 cycles.
- Byte counter increments on each accepted byte. If the 15th byte is accepted without completing the instruction, go to DONE with out_err=1 and out_len=15; remaining fields hold whatever was parsed.
- in_valid=0 stalls any state with no state change.

Test Plan:
- 48 89 E5 -> len=3, rex=1000, opcode=89, has_modrm=1, modrm=E5, disp=0, imm=0.
- 66 05 34 12 -> len=4, pfx=00001, imm=2, has_modrm=0.
- 48 B8 followed by 8 bytes -> len=10, imm=8; 8B 44 24 08 -> len=4, has_sib=1, disp=1.
- 0F 84 + 4 bytes -> len=6, esc=1, opcode=84, has_modrm=0, imm=4; F6 C0 05 -> len=3, imm=1; F6 D8 -> len=2, imm=0.
- Sixteen consecutive 66 bytes -> record after 15 bytes with err=1, len=15; the 16th 66 starts the next instruction.
- Hold out_ready=0 for 5 cycles after 90 -> record stable and in_ready=0. Assert flush mid-instruction (after 48 8B) -> out_valid=0; next C3 gives len=1, rex=0.
